btn_cmd_encoder: RTL and testbench

- Input conditioning stage directly upstream of the stack calculator controller.
- Synchronizes and debounces the four raw Basys3 push buttons.
- Captures a button chord (the OR of all buttons pressed between first press and full release) as a 4-bit instruction code.
- Presents the code to the controller through a valid/ack handshake, so each physical press yields exactly one instruction.

---
 rtl/btn_cmd_encoder.sv | 154 +++++++++++++++
 tb/tb_btn_cmd_encoder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_cmd_encoder.sv
// rtl/btn_cmd_encoder.sv - push-button synchronizer, debouncer and chord-to-command encoder
// Each press-and-release chord becomes one 4-bit command on a valid/ack handshake.
module btn_cmd_encoder #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] btns,
    input  logic       cmd_ack,
    output logic [3:0] cmd,
    output logic       cmd_valid,
    output logic       cmd_dropped,
    output logic [3:0] btn_state
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        LOCKOUT = 2'd0,
        IDLE    = 2'd1,
        CAPTURE = 2'd2,
        EMIT    = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [CNT_W-1:0] r_db_cnt [4];
    logic [3:0]       r_btn_state;

    logic [CNT_W-1:0] r_lock_cnt;
    logic [CNT_W-1:0] w_lock_cnt_nxt;
    logic [3:0]       r_acc;
    logic [3:0]       w_acc_nxt;
    logic [3:0]       r_cmd;
    logic [3:0]       w_cmd_nxt;
    logic             r_cmd_valid;
    logic             w_cmd_valid_nxt;
    logic             r_cmd_dropped;
    logic             w_cmd_dropped_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btns;
            r_sync2 <= r_sync1;
        end
    end

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_btn_state <= '0;
            for (int i = 0; i < 4; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_btn_state[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == CNT_MAX) begin
                    r_btn_state[i] <= r_sync2[i];
                    r_db_cnt[i]    <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= LOCKOUT;
            r_lock_cnt    <= '0;
            r_acc         <= '0;
            r_cmd         <= '0;
            r_cmd_valid   <= 1'b0;
            r_cmd_dropped <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_lock_cnt    <= w_lock_cnt_nxt;
            r_acc         <= w_acc_nxt;
            r_cmd         <= w_cmd_nxt;
            r_cmd_valid   <= w_cmd_valid_nxt;
            r_cmd_dropped <= w_cmd_dropped_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_lock_cnt_nxt    = '0;
        w_acc_nxt         = r_acc;
        w_cmd_nxt         = r_cmd;
        w_cmd_valid_nxt   = r_cmd_valid;
        w_cmd_dropped_nxt = 1'b0;

        if (r_cmd_valid && cmd_ack) begin
            w_cmd_valid_nxt = 1'b0;
        end

        case (r_state)
            // Exit only after all raw inputs have been quiet long enough, so a
            // button held through reset never turns into a command.
            LOCKOUT: begin
                w_acc_nxt = '0;
                if (r_sync2 != 4'b0000) begin
                    w_lock_cnt_nxt = '0;
                end else if (r_lock_cnt == CNT_MAX) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_lock_cnt_nxt = r_lock_cnt + CNT_ONE;
                end
            end
            IDLE: begin
                w_acc_nxt = '0;
                if (r_btn_state != 4'b0000) begin
                    w_acc_nxt   = r_btn_state;
                    w_state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                w_acc_nxt = r_acc | r_btn_state;
                if (r_btn_state == 4'b0000) begin
                    w_state_nxt = EMIT;
                end
            end
            EMIT: begin
                // An ack in this same cycle frees the slot, so the new code reloads back-to-back.
                if (!r_cmd_valid || cmd_ack) begin
                    w_cmd_nxt       = r_acc;
                    w_cmd_valid_nxt = 1'b1;
                end else begin
                    w_cmd_dropped_nxt = 1'b1;
                end
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = LOCKOUT;
            end
        endcase
    end

    assign cmd         = r_cmd;
    assign cmd_valid   = r_cmd_valid;
    assign cmd_dropped = r_cmd_dropped;
    assign btn_state   = r_btn_state;

endmodule

// File: tb/tb_btn_cmd_encoder.sv
// tb/tb_btn_cmd_encoder.sv - directed self-checking bench for btn_cmd_encoder
// Uses DEBOUNCE_CYCLES=4: a release produces cmd_valid 8 cycles later.
module tb_btn_cmd_encoder;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] btns;
    logic       cmd_ack;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       cmd_dropped;
    logic [3:0] btn_state;

    int vec_cnt = 0;
    int err_cnt = 0;

    btn_cmd_encoder #(
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btns       (btns),
        .cmd_ack    (cmd_ack),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .cmd_dropped(cmd_dropped),
        .btn_state  (btn_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_btns(input logic [3:0] code, input int cycles);
        btns = code;
        repeat (cycles) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        btns    = 4'b0000;
        cmd_ack = 1'b0;
        repeat (3) tick();
        vec_cnt++;
        if ({cmd_valid, cmd_dropped, cmd, btn_state} !== 10'b0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got %b exp 0000000000", {cmd_valid, cmd_dropped, cmd, btn_state});
        end
        reset_n = 1'b1;
        repeat (10) tick();
        vec_cnt++;
        if (cmd_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_idle_valid: got %b exp 0", cmd_valid);
        end
    endtask

    task automatic test_single_press();
        hold_btns(4'b0001, 10);
        vec_cnt++;
        if (btn_state !== 4'b0001) begin
            err_cnt++;
            $display("FAIL single_btn_state: got %b exp 0001", btn_state);
        end
        hold_btns(4'b0001, 10);
        btns = 4'b0000;
        for (int i = 1; i <= 8; i++) begin
            tick();
            vec_cnt++;
            if (i < 8 && cmd_valid !== 1'b0) begin
                err_cnt++;
                $display("FAIL single_early_valid: cycle %0d got %b exp 0", i, cmd_valid);
            end else if (i == 8 && {cmd_valid, cmd} !== {1'b1, 4'd1}) begin
                err_cnt++;
                $display("FAIL single_emit: got valid=%b cmd=%0d exp valid=1 cmd=1", cmd_valid, cmd);
            end
        end
        repeat (3) tick();
        vec_cnt++;
        if ({cmd_valid, cmd} !== {1'b1, 4'd1}) begin
            err_cnt++;
            $display("FAIL single_hold: got valid=%b cmd=%0d exp valid=1 cmd=1", cmd_valid, cmd);
        end
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        vec_cnt++;
        if (cmd_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL single_ack: got %b exp 0", cmd_valid);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            vec_cnt++;
            if (cmd_valid !== 1'b0) begin
                err_cnt++;
                $display("FAIL single_once: cycle %0d got %b exp 0", i, cmd_valid);
            end
        end
    endtask

    task automatic test_chord();
        logic [3:0] seq [3];
        seq[0] = 4'b0001;
        seq[1] = 4'b0101;
        seq[2] = 4'b0100;
        for (int s = 0; s < 3; s++) begin
            btns = seq[s];
            for (int i = 0; i < 10; i++) begin
                tick();
                vec_cnt++;
                if (cmd_valid !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL chord_held_valid: step %0d got %b exp 0", s, cmd_valid);
                end
            end
        end
        btns = 4'b0000;
        repeat (8) tick();
        vec_cnt++;
        if ({cmd_valid, cmd} !== {1'b1, 4'd5}) begin
            err_cnt++;
            $display("FAIL chord_emit: got valid=%b cmd=%0d exp valid=1 cmd=5", cmd_valid, cmd);
        end
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
    endtask

    task automatic test_glitch();
        btns = 4'b0010;
        for (int i = 0; i < 18; i++) begin
            if (i == 3) btns = 4'b0000;
            tick();
            vec_cnt++;
            if ({btn_state, cmd_valid} !== 5'b00000) begin
                err_cnt++;
                $display("FAIL glitch_reject: cycle %0d got state=%b valid=%b exp 0000/0", i, btn_state, cmd_valid);
            end
        end
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        tick();
        vec_cnt++;
        if (cmd_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL idle_ack_ignored: got %b exp 0", cmd_valid);
        end
        hold_btns(4'b0010, 6);
        btns = 4'b0000;
        repeat (8) tick();
        vec_cnt++;
        if ({cmd_valid, cmd} !== {1'b1, 4'd2}) begin
            err_cnt++;
            $display("FAIL pulse6_emit: got valid=%b cmd=%0d exp valid=1 cmd=2", cmd_valid, cmd);
        end
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
    endtask

    task automatic test_overflow();
        hold_btns(4'b0001, 20);
        btns = 4'b0000;
        repeat (8) tick();
        vec_cnt++;
        if ({cmd_valid, cmd} !== {1'b1, 4'd1}) begin
            err_cnt++;
            $display("FAIL ovf_first: got valid=%b cmd=%0d exp valid=1 cmd=1", cmd_valid, cmd);
        end
        hold_btns(4'b0010, 20);
        btns = 4'b0000;
        for (int i = 1; i <= 9; i++) begin
            tick();
            vec_cnt++;
            if ({cmd_dropped, cmd_valid, cmd} !== {(i == 8), 1'b1, 4'd1}) begin
                err_cnt++;
                $display("FAIL ovf_drop: cycle %0d got drop=%b valid=%b cmd=%0d exp drop=%b valid=1 cmd=1",
                         i, cmd_dropped, cmd_valid, cmd, (i == 8));
            end
        end
    endtask

    task automatic test_back_to_back();
        hold_btns(4'b0110, 20);
        btns = 4'b0000;
        repeat (7) tick();
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        vec_cnt++;
        if ({cmd_dropped, cmd_valid, cmd} !== {1'b0, 1'b1, 4'd6}) begin
            err_cnt++;
            $display("FAIL b2b_reload: got drop=%b valid=%b cmd=%0d exp drop=0 valid=1 cmd=6", cmd_dropped, cmd_valid, cmd);
        end
        tick();
        vec_cnt++;
        if ({cmd_valid, cmd} !== {1'b1, 4'd6}) begin
            err_cnt++;
            $display("FAIL b2b_hold: got valid=%b cmd=%0d exp valid=1 cmd=6", cmd_valid, cmd);
        end
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        vec_cnt++;
        if (cmd_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_clear: got %b exp 0", cmd_valid);
        end
    endtask

    task automatic test_held_through_reset();
        reset_n = 1'b0;
        btns    = 4'b1000;
        repeat (3) tick();
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            vec_cnt++;
            if (cmd_valid !== 1'b0) begin
                err_cnt++;
                $display("FAIL held_no_cmd: cycle %0d got %b exp 0", i, cmd_valid);
            end
        end
        vec_cnt++;
        if (btn_state !== 4'b1000) begin
            err_cnt++;
            $display("FAIL held_btn_state: got %b exp 1000", btn_state);
        end
        btns = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            tick();
            vec_cnt++;
            if ({cmd_valid, cmd_dropped} !== 2'b00) begin
                err_cnt++;
                $display("FAIL held_release: cycle %0d got valid=%b drop=%b exp 0/0", i, cmd_valid, cmd_dropped);
            end
        end
        hold_btns(4'b1001, 20);
        btns = 4'b0000;
        repeat (8) tick();
        vec_cnt++;
        if ({cmd_valid, cmd} !== {1'b1, 4'd9}) begin
            err_cnt++;
            $display("FAIL held_next_press: got valid=%b cmd=%0d exp valid=1 cmd=9", cmd_valid, cmd);
        end
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
    endtask

    task automatic test_async_reset();
        hold_btns(4'b0001, 20);
        btns = 4'b0000;
        repeat (8) tick();
        hold_btns(4'b1101, 15);
        vec_cnt++;
        if ({cmd_valid, cmd, btn_state} !== {1'b1, 4'd1, 4'b1101}) begin
            err_cnt++;
            $display("FAIL async_pre: got valid=%b cmd=%0d state=%b exp valid=1 cmd=1 state=1101", cmd_valid, cmd, btn_state);
        end
        #2;
        reset_n = 1'b0;
        #1;
        vec_cnt++;
        if ({cmd_valid, cmd_dropped, cmd, btn_state} !== 10'b0) begin
            err_cnt++;
            $display("FAIL async_clear: got %b exp 0000000000", {cmd_valid, cmd_dropped, cmd, btn_state});
        end
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (10) tick();
        btns = 4'b0000;
        for (int i = 0; i < 30; i++) begin
            tick();
            vec_cnt++;
            if (cmd_valid !== 1'b0) begin
                err_cnt++;
                $display("FAIL async_no_cmd: cycle %0d got %b exp 0", i, cmd_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_chord();
        test_glitch();
        test_overflow();
        test_back_to_back();
        test_held_through_reset();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
